// File: rtl/music_record_buffer.sv
// music_record_buffer: records the live note code once per sample slot into a
// small RAM, then replays the recorded words at the same slot rate.
// Output contract: data_out is meaningful only while output_ready is high; there
// is no back-pressure, so the consumer must take each word as it is presented.
module music_record_buffer #(
    parameter int DATA_WIDTH      = 10,
    parameter int DEPTH           = 64,
    parameter int DEPTH_BIT       = 7,
    parameter int SAMPLE_INTERVAL = 21739130
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rec_start,
    input  logic                  rec_stop,
    input  logic                  play_start,
    input  logic                  play_stop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_ready,
    output logic                  recording,
    output logic                  full,
    output logic                  play_done,
    output logic [DEPTH_BIT-1:0]  count
);

    localparam int SC_W = $clog2(SAMPLE_INTERVAL + 1);
    localparam int AW   = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [SC_W-1:0]       sample_cnt;
    logic [DEPTH_BIT-1:0]  ptr;
    // Set at the end of the final slot so the last word still gets a full slot
    // on data_out before playback closes one cycle later.
    logic                  last_word;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic slot_end;
    logic rec_begin;
    logic rec_write;
    logic rec_full;
    logic play_begin;
    logic play_empty;
    logic play_abort;
    logic play_finish;

    assign slot_end = (sample_cnt == SC_W'(SAMPLE_INTERVAL));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and the one-cycle action strobes used by the datapath.
    always_comb begin
        state_nxt   = state;
        rec_begin   = 1'b0;
        rec_write   = 1'b0;
        rec_full    = 1'b0;
        play_begin  = 1'b0;
        play_empty  = 1'b0;
        play_abort  = 1'b0;
        play_finish = 1'b0;
        case (state)
            IDLE: begin
                if (rec_start) begin
                    rec_begin = 1'b1;
                    state_nxt = REC;
                end else if (play_start) begin
                    if (count != '0) begin
                        play_begin = 1'b1;
                        state_nxt  = PLAY;
                    end else begin
                        play_empty = 1'b1;
                    end
                end
            end
            REC: begin
                // A stop wins over a slot write landing in the same cycle.
                if (rec_stop) begin
                    state_nxt = IDLE;
                end else if (slot_end) begin
                    rec_write = 1'b1;
                    if (count == DEPTH_BIT'(DEPTH - 1)) begin
                        rec_full  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            PLAY: begin
                if (play_stop) begin
                    play_abort = 1'b1;
                    state_nxt  = IDLE;
                end else if (last_word) begin
                    play_finish = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            ptr          <= '0;
            sample_cnt   <= SC_W'(1);
            last_word    <= 1'b0;
            data_out     <= '0;
            output_ready <= 1'b0;
            recording    <= 1'b0;
            full         <= 1'b0;
            play_done    <= 1'b0;
        end else begin
            play_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rec_begin) begin
                        count      <= '0;
                        sample_cnt <= SC_W'(1);
                        full       <= 1'b0;
                        recording  <= 1'b1;
                    end
                    if (play_begin) begin
                        ptr        <= '0;
                        sample_cnt <= SC_W'(1);
                        last_word  <= 1'b0;
                    end
                    if (play_empty) play_done <= 1'b1;
                end
                REC: begin
                    if (rec_stop) begin
                        recording <= 1'b0;
                    end else begin
                        sample_cnt <= slot_end ? SC_W'(1) : sample_cnt + SC_W'(1);
                        if (rec_write) count <= count + DEPTH_BIT'(1);
                        if (rec_full) begin
                            full      <= 1'b1;
                            recording <= 1'b0;
                        end
                    end
                end
                PLAY: begin
                    if (play_abort || play_finish) begin
                        output_ready <= 1'b0;
                        data_out     <= '0;
                        last_word    <= 1'b0;
                        play_done    <= play_finish;
                    end else begin
                        data_out     <= mem[ptr[AW-1:0]];
                        output_ready <= 1'b1;
                        if (slot_end) begin
                            sample_cnt <= SC_W'(1);
                            if (ptr == count - DEPTH_BIT'(1)) last_word <= 1'b1;
                            else                              ptr       <= ptr + DEPTH_BIT'(1);
                        end else begin
                            sample_cnt <= sample_cnt + SC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Sample RAM; contents survive reset, count alone says what is valid.
    always_ff @(posedge clk) begin
        if (rec_write) mem[count[AW-1:0]] <= data_in;
    end

endmodule

// File: tb/tb_music_record_buffer.sv
// Bench for music_record_buffer with a short slot (4 cycles) and 8-word RAM.
// The model is a queue of the words expected to be recorded, in order.
module tb_music_record_buffer;

    localparam int DW    = 10;
    localparam int DEPTH = 8;
    localparam int DB    = 4;
    localparam int SI    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rec_start = 1'b0;
    logic          rec_stop = 1'b0;
    logic          play_start = 1'b0;
    logic          play_stop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          output_ready;
    logic          recording;
    logic          full;
    logic          play_done;
    logic [DB-1:0] count;

    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Clock.
    always #5 clk = ~clk;

    music_record_buffer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .DEPTH_BIT(DB), .SAMPLE_INTERVAL(SI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rec_start(rec_start), .rec_stop(rec_stop),
        .play_start(play_start), .play_stop(play_stop), .data_in(data_in),
        .data_out(data_out), .output_ready(output_ready), .recording(recording),
        .full(full), .play_done(play_done), .count(count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: record n random words then stop; fills the model queue.
    task automatic record_random(input int n);
        exp_q.delete();
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            data_in = DW'($urandom_range(1, 1023));
            repeat (SI) tick();
            exp_q.push_back(data_in);
        end
        rec_stop = 1'b1; tick(); rec_stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_checks++; if (data_out !== '0) $display("FAIL reset_data_out got=%h exp=0", data_out); else n_pass++;
        n_checks++; if (output_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", output_ready); else n_pass++;
        n_checks++; if (recording !== 1'b0) $display("FAIL reset_recording got=%b exp=0", recording); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
        n_checks++; if (play_done !== 1'b0) $display("FAIL reset_play_done got=%b exp=0", play_done); else n_pass++;
        n_checks++; if (count !== '0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_record();
        logic [DW-1:0] words [3];
        words[0] = 10'h042; words[1] = 10'h012; words[2] = 10'h022;
        exp_q.delete();
        rec_start = 1'b1; data_in = words[0]; tick(); rec_start = 1'b0;
        n_checks++; if (recording !== 1'b1) $display("FAIL rec_enter got=%b exp=1", recording); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            data_in = words[k];
            repeat (SI) tick();
            exp_q.push_back(words[k]);
            n_checks++; if (count !== DB'(k + 1)) $display("FAIL rec_count k=%0d got=%0d exp=%0d", k, count, k + 1); else n_pass++;
        end
        rec_stop = 1'b1; tick(); rec_stop = 1'b0;
        data_in = DW'($urandom_range(1, 1023));
        n_checks++; if (recording !== 1'b0) $display("FAIL rec_stop_recording got=%b exp=0", recording); else n_pass++;
        n_checks++; if (count !== DB'(3)) $display("FAIL rec_stop_count got=%0d exp=3", count); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL rec_stop_full got=%b exp=0", full); else n_pass++;
    endtask

    // Plays the whole recording and compares it against the model queue.
    task automatic test_playback(input string tag);
        int n;
        n = exp_q.size();
        play_start = 1'b1; tick(); play_start = 1'b0;
        n_checks++; if (output_ready !== 1'b0) $display("FAIL %s early_ready got=%b exp=0", tag, output_ready); else n_pass++;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < SI; j++) begin
                tick();
                data_in = DW'($urandom_range(1, 1023));
                n_checks++; if (output_ready !== 1'b1) $display("FAIL %s ready w=%0d c=%0d got=%b exp=1", tag, k, j, output_ready); else n_pass++;
                n_checks++; if (data_out !== exp_q[k]) $display("FAIL %s data w=%0d c=%0d got=%h exp=%h", tag, k, j, data_out, exp_q[k]); else n_pass++;
                n_checks++; if (play_done !== 1'b0) $display("FAIL %s early_done w=%0d c=%0d got=%b exp=0", tag, k, j, play_done); else n_pass++;
            end
        end
        tick();
        n_checks++; if (output_ready !== 1'b0) $display("FAIL %s end_ready got=%b exp=0", tag, output_ready); else n_pass++;
        n_checks++; if (data_out !== '0) $display("FAIL %s end_data got=%h exp=0", tag, data_out); else n_pass++;
        n_checks++; if (play_done !== 1'b1) $display("FAIL %s done_pulse got=%b exp=1", tag, play_done); else n_pass++;
        tick();
        n_checks++; if (play_done !== 1'b0) $display("FAIL %s done_width got=%b exp=0", tag, play_done); else n_pass++;
        n_checks++; if (count !== DB'(n)) $display("FAIL %s count_kept got=%0d exp=%0d", tag, count, n); else n_pass++;
    endtask

    task automatic test_full();
        int exp_cnt;
        exp_q.delete();
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if ((c - 1) % SI == 0) data_in = DW'($urandom_range(1, 1023));
            if (c % SI == 0 && c <= DEPTH * SI) exp_q.push_back(data_in);
            tick();
            exp_cnt = (c / SI < DEPTH) ? c / SI : DEPTH;
            n_checks++; if (count !== DB'(exp_cnt)) $display("FAIL full_count c=%0d got=%0d exp=%0d", c, count, exp_cnt); else n_pass++;
            n_checks++; if (recording !== (c < DEPTH * SI)) $display("FAIL full_recording c=%0d got=%b", c, recording); else n_pass++;
            n_checks++; if (full !== (c >= DEPTH * SI)) $display("FAIL full_flag c=%0d got=%b", c, full); else n_pass++;
        end
        test_playback("full_play");
        n_checks++; if (full !== 1'b1) $display("FAIL full_held got=%b exp=1", full); else n_pass++;
    endtask

    task automatic test_stop_on_write();
        exp_q.delete();
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        n_checks++; if (full !== 1'b0) $display("FAIL full_cleared got=%b exp=0", full); else n_pass++;
        data_in = DW'($urandom_range(1, 1023));
        repeat (SI) tick();
        exp_q.push_back(data_in);
        n_checks++; if (count !== DB'(1)) $display("FAIL sow_first got=%0d exp=1", count); else n_pass++;
        data_in = DW'($urandom_range(1, 1023));
        repeat (SI - 1) tick();
        rec_stop = 1'b1; tick(); rec_stop = 1'b0;
        n_checks++; if (count !== DB'(1)) $display("FAIL sow_count got=%0d exp=1", count); else n_pass++;
        n_checks++; if (recording !== 1'b0) $display("FAIL sow_recording got=%b exp=0", recording); else n_pass++;
        test_playback("single_play");
    endtask

    task automatic test_start_priority();
        rec_start = 1'b1; play_start = 1'b1; tick(); rec_start = 1'b0; play_start = 1'b0;
        n_checks++; if (recording !== 1'b1) $display("FAIL prio_recording got=%b exp=1", recording); else n_pass++;
        n_checks++; if (output_ready !== 1'b0) $display("FAIL prio_ready got=%b exp=0", output_ready); else n_pass++;
        n_checks++; if (count !== '0) $display("FAIL prio_count got=%0d exp=0", count); else n_pass++;
        rec_stop = 1'b1; tick(); rec_stop = 1'b0;
        n_checks++; if (recording !== 1'b0) $display("FAIL prio_stop got=%b exp=0", recording); else n_pass++;
    endtask

    task automatic test_empty_play();
        play_start = 1'b1; tick(); play_start = 1'b0;
        n_checks++; if (play_done !== 1'b1) $display("FAIL empty_done got=%b exp=1", play_done); else n_pass++;
        n_checks++; if (output_ready !== 1'b0) $display("FAIL empty_ready got=%b exp=0", output_ready); else n_pass++;
        tick();
        n_checks++; if (play_done !== 1'b0) $display("FAIL empty_done_width got=%b exp=0", play_done); else n_pass++;
        n_checks++; if (output_ready !== 1'b0) $display("FAIL empty_ready_after got=%b exp=0", output_ready); else n_pass++;
    endtask

    task automatic test_play_stop();
        record_random(3);
        play_start = 1'b1; tick(); play_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_checks++; if (data_out !== exp_q[(c - 1) / SI]) $display("FAIL pstop_data c=%0d got=%h exp=%h", c, data_out, exp_q[(c - 1) / SI]); else n_pass++;
        end
        play_stop = 1'b1; tick(); play_stop = 1'b0;
        n_checks++; if (output_ready !== 1'b0) $display("FAIL pstop_ready got=%b exp=0", output_ready); else n_pass++;
        n_checks++; if (data_out !== '0) $display("FAIL pstop_data_zero got=%h exp=0", data_out); else n_pass++;
        n_checks++; if (play_done !== 1'b0) $display("FAIL pstop_done got=%b exp=0", play_done); else n_pass++;
        tick();
        n_checks++; if (play_done !== 1'b0) $display("FAIL pstop_done_late got=%b exp=0", play_done); else n_pass++;
        n_checks++; if (count !== DB'(3)) $display("FAIL pstop_count got=%0d exp=3", count); else n_pass++;
    endtask

    task automatic test_reset_mid_play();
        record_random(3);
        play_start = 1'b1; tick(); play_start = 1'b0;
        repeat (3) tick();
        n_checks++; if (output_ready !== 1'b1) $display("FAIL rmp_playing got=%b exp=1", output_ready); else n_pass++;
        rst_n = 1'b0;
        #2;
        n_checks++; if (output_ready !== 1'b0) $display("FAIL rmp_ready got=%b exp=0", output_ready); else n_pass++;
        n_checks++; if (data_out !== '0) $display("FAIL rmp_data got=%h exp=0", data_out); else n_pass++;
        n_checks++; if (count !== '0) $display("FAIL rmp_count got=%0d exp=0", count); else n_pass++;
        #4;
        rst_n = 1'b1;
        tick();
        play_start = 1'b1; tick(); play_start = 1'b0;
        n_checks++; if (play_done !== 1'b1) $display("FAIL rmp_done got=%b exp=1", play_done); else n_pass++;
        n_checks++; if (output_ready !== 1'b0) $display("FAIL rmp_ready_after got=%b exp=0", output_ready); else n_pass++;
        tick();
        n_checks++; if (play_done !== 1'b0) $display("FAIL rmp_done_width got=%b exp=0", play_done); else n_pass++;
        n_checks++; if (output_ready !== 1'b0) $display("FAIL rmp_ready_stays got=%b exp=0", output_ready); else n_pass++;
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_record();
        test_playback("basic_play");
        test_full();
        test_stop_on_write();
        test_start_priority();
        test_empty_play();
        test_play_stop();
        test_reset_mid_play();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
